// File: rtl/serial_to_parallel.sv
// -----------------------------------------------------------------------------
// serial_to_parallel
//
// Purpose:
//   Deserializer placed directly after the single-bit capture flip-flop. Bits
//   qualified by sin_valid are shifted into a WIDTH-bit shift register. Each
//   completed word is copied into a one-word holding register and offered on a
//   valid/ready port, so the shifter keeps filling while the word waits.
//
// Configuration:
//   SERIAL_TO_PARALLEL_PARITY_EN - when defined, each frame is WIDTH data bits
//   followed by one even-parity bit. The parity bit is not stored in pout, and
//   parity_err flags a word whose data bits XOR the parity bit give 1. When it
//   is undefined, a frame is WIDTH bits and parity_err is tied to 0.
//
// Parameters:
//   WIDTH      bits per word, 2..32
//   MSB_FIRST  1: first received bit lands in pout[WIDTH-1]; 0: in pout[0]
//
// Ports:
//   clk         in   clock, all state changes on the rising edge
//   rst         in   asynchronous, active-high reset
//   sin         in   serial data bit from the upstream flip-flop q
//   sin_valid   in   sin carries a bit this cycle
//   sin_ready   out  a bit is accepted this cycle
//   pout        out  assembled word (WIDTH bits)
//   pout_valid  out  pout holds a complete word
//   pout_ready  in   consumer takes the word this cycle
//   parity_err  out  parity result for the word on pout, valid with pout_valid
// -----------------------------------------------------------------------------
module serial_to_parallel #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             sin_ready,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             parity_err
);

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    localparam int               CNT_W    = $clog2(FRAME);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             hold_full_q, hold_full_d;
    logic             parity_err_q, parity_err_d;

    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] sh_shift;

    // Stall only at the final bit position of a frame while the holding
    // register is still occupied; depends on registers alone.
    assign last_bit  = (cnt_q == CNT_LAST);
    assign sin_ready = !(last_bit && hold_full_q);
    assign accept    = sin_valid && sin_ready;

    assign sh_shift = MSB_FIRST ? {sh_q[WIDTH-2:0], sin}
                                : {sin, sh_q[WIDTH-1:1]};

    // NOTE: every signal assigned here receives a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sh_d         = sh_q;
        cnt_d        = cnt_q;
        pout_d       = pout_q;
        hold_full_d  = hold_full_q;
        parity_err_d = parity_err_q;

        // Release. A word completion cannot coincide with this because
        // sin_ready is low at the last bit whenever hold_full_q is set, so the
        // completion below can safely override it.
        if (hold_full_q && pout_ready) begin
            hold_full_d = 1'b0;
        end

        if (accept) begin
            if (last_bit) begin
                cnt_d       = '0;
                hold_full_d = 1'b1;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
                // The final bit is the parity bit: the data is already in sh_q.
                pout_d       = sh_q;
                parity_err_d = (^sh_q) ^ sin;
`else
                sh_d         = sh_shift;
                pout_d       = sh_shift;
`endif
            end else begin
                sh_d  = sh_shift;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q         <= '0;
            cnt_q        <= '0;
            pout_q       <= '0;
            hold_full_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            sh_q         <= sh_d;
            cnt_q        <= cnt_d;
            pout_q       <= pout_d;
            hold_full_q  <= hold_full_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign pout       = pout_q;
    assign pout_valid = hold_full_q;

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    assign parity_err = parity_err_q;
`else
    // Without a parity bit there is nothing to check.
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// -----------------------------------------------------------------------------
// tb_serial_to_parallel
//
// Two WIDTH=8 instances run in lockstep on the same stimulus: one with
// MSB_FIRST=1 (suffix _m) and one with MSB_FIRST=0 (suffix _l). Inputs are
// driven 1 time unit after the rising edge and outputs are sampled at that
// point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_serial_to_parallel;

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic       sin_valid;
    logic       pout_ready;

    logic       sin_ready_m, pout_valid_m, parity_err_m;
    logic [7:0] pout_m;
    logic       sin_ready_l, pout_valid_l, parity_err_l;
    logic [7:0] pout_l;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sin_ready  (sin_ready_m),
        .pout       (pout_m),
        .pout_valid (pout_valid_m),
        .pout_ready (pout_ready),
        .parity_err (parity_err_m)
    );

    serial_to_parallel #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sin_ready  (sin_ready_l),
        .pout       (pout_l),
        .pout_valid (pout_valid_l),
        .pout_ready (pout_ready),
        .parity_err (parity_err_l)
    );

    // Bit i of a frame: data bits in transmit order (w[7] first), then parity.
    function automatic logic frame_bit(input logic [7:0] w, input logic par, input int i);
        return (i < 8) ? w[7-i] : par;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one bit and hold it until accepted, bounded by a cycle budget.
    task automatic send_bit(input logic b);
        int waited = 0;
        sin       = b;
        sin_valid = 1'b1;
        while (!sin_ready_m && waited < 40) begin
            step();
            waited++;
        end
        if (!sin_ready_m) begin
            vectors++;
            miscompares++;
            $display("FAIL send_bit_timeout: sin_ready stayed 0 for %0d cycles, required 1", waited);
        end
        step();
        sin_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        pout_ready = 1'b0;
        repeat (3) step();
        vectors++;
        if (pout_m !== 8'h00 || pout_valid_m !== 1'b0 || sin_ready_m !== 1'b1 || parity_err_m !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: pout=%h valid=%b ready=%b perr=%b, required 00/0/1/0",
                     pout_m, pout_valid_m, sin_ready_m, parity_err_m);
        end
        rst = 1'b0;
        step();
    endtask

    // B2 back-to-back with pout_ready=1: valid exactly one cycle after the last accept.
    task automatic test_msb_first();
        pout_ready = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            sin       = frame_bit(8'hB2, 1'b0, i);
            sin_valid = 1'b1;
            step();
            vectors++;
            if (pout_valid_m !== (i == FRAME - 1)) begin
                miscompares++;
                $display("FAIL msb_valid_edge%0d: got %b, required %b", i, pout_valid_m, (i == FRAME - 1));
            end
        end
        sin_valid = 1'b0;
        vectors++;
        if (pout_m !== 8'hB2) begin
            miscompares++;
            $display("FAIL msb_word: got %h, required b2", pout_m);
        end
        vectors++;
        if (parity_err_m !== 1'b0) begin
            miscompares++;
            $display("FAIL msb_parity: got %b, required 0", parity_err_m);
        end
        step();
        vectors++;
        if (pout_valid_m !== 1'b0) begin
            miscompares++;
            $display("FAIL msb_valid_one_cycle: got %b, required 0", pout_valid_m);
        end
    endtask

    // The LSB-first instance saw the same stream.
    task automatic test_lsb_first();
        vectors++;
        if (pout_l !== 8'h4D) begin
            miscompares++;
            $display("FAIL lsb_word: got %h, required 4d", pout_l);
        end
        vectors++;
        if (pout_valid_l !== 1'b0) begin
            miscompares++;
            $display("FAIL lsb_valid_released: got %b, required 0", pout_valid_l);
        end
    endtask

    // Two frames with no gap: sin_ready never drops, valid pulses once per frame.
    task automatic test_back_to_back();
        logic [7:0] w;
        pout_ready = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            w         = (i < FRAME) ? 8'hB2 : 8'h5A;
            sin       = frame_bit(w, 1'b0, i % FRAME);
            sin_valid = 1'b1;
            vectors++;
            if (sin_ready_m !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready_bit%0d: got %b, required 1", i, sin_ready_m);
            end
            step();
            vectors++;
            if (pout_valid_m !== ((i % FRAME) == FRAME - 1)) begin
                miscompares++;
                $display("FAIL b2b_valid_edge%0d: got %b, required %b", i, pout_valid_m, ((i % FRAME) == FRAME - 1));
            end
            if (i == FRAME - 1) begin
                vectors++;
                if (pout_m !== 8'hB2) begin
                    miscompares++;
                    $display("FAIL b2b_word0: got %h, required b2", pout_m);
                end
            end
        end
        sin_valid = 1'b0;
        vectors++;
        if (pout_m !== 8'h5A || pout_l !== 8'h5A) begin
            miscompares++;
            $display("FAIL b2b_word1: msb=%h lsb=%h, required 5a/5a", pout_m, pout_l);
        end
        step();
    endtask

    // Hold full, fill FRAME-1 bits of the next word, stall, release, finish.
    task automatic test_stall();
        pout_ready = 1'b0;
        for (int i = 0; i < FRAME; i++) send_bit(frame_bit(8'hB2, 1'b0, i));
        vectors++;
        if (pout_valid_m !== 1'b1 || pout_m !== 8'hB2) begin
            miscompares++;
            $display("FAIL stall_first_word: valid=%b pout=%h, required 1/b2", pout_valid_m, pout_m);
        end
        for (int i = 0; i < FRAME - 1; i++) send_bit(frame_bit(8'h5A, 1'b0, i));
        vectors++;
        if (sin_ready_m !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_ready_drop: got %b, required 0", sin_ready_m);
        end
        // Offer the final bit while stalled; it must not be taken.
        sin       = frame_bit(8'h5A, 1'b0, FRAME - 1);
        sin_valid = 1'b1;
        repeat (3) step();
        vectors++;
        if (sin_ready_m !== 1'b0 || pout_valid_m !== 1'b1 || pout_m !== 8'hB2) begin
            miscompares++;
            $display("FAIL stall_hold: ready=%b valid=%b pout=%h, required 0/1/b2",
                     sin_ready_m, pout_valid_m, pout_m);
        end
        pout_ready = 1'b1;
        step();
        pout_ready = 1'b0;
        vectors++;
        if (pout_valid_m !== 1'b0 || sin_ready_m !== 1'b1 || pout_m !== 8'hB2) begin
            miscompares++;
            $display("FAIL stall_release: valid=%b ready=%b pout=%h, required 0/1/b2",
                     pout_valid_m, sin_ready_m, pout_m);
        end
        step();
        sin_valid = 1'b0;
        vectors++;
        if (pout_valid_m !== 1'b1 || pout_m !== 8'h5A) begin
            miscompares++;
            $display("FAIL stall_second_word: valid=%b pout=%h, required 1/5a", pout_valid_m, pout_m);
        end
        pout_ready = 1'b1;
        step();
        pout_ready = 1'b0;
    endtask

    // Async reset mid-frame with a full holding register, then a clean FF frame.
    task automatic test_async_reset();
        pout_ready = 1'b0;
        for (int i = 0; i < FRAME; i++) send_bit(frame_bit(8'hB2, 1'b0, i));
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (pout_m !== 8'h00 || pout_valid_m !== 1'b0 || sin_ready_m !== 1'b1 || parity_err_m !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: pout=%h valid=%b ready=%b perr=%b, required 00/0/1/0",
                     pout_m, pout_valid_m, sin_ready_m, parity_err_m);
        end
        step();
        rst = 1'b0;
        pout_ready = 1'b1;
        for (int i = 0; i < FRAME - 1; i++) send_bit(frame_bit(8'hFF, 1'b0, i));
        vectors++;
        if (pout_valid_m !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frame_early: valid=%b after %0d bits, required 0", pout_valid_m, FRAME - 1);
        end
        send_bit(frame_bit(8'hFF, 1'b0, FRAME - 1));
        vectors++;
        if (pout_valid_m !== 1'b1 || pout_m !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_frame_word: valid=%b pout=%h, required 1/ff", pout_valid_m, pout_m);
        end
        step();
    endtask

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    task automatic test_parity();
        pout_ready = 1'b0;
        for (int i = 0; i < FRAME; i++) send_bit(frame_bit(8'hB2, 1'b0, i));
        vectors++;
        if (parity_err_m !== 1'b0 || pout_m !== 8'hB2) begin
            miscompares++;
            $display("FAIL parity_good: perr=%b pout=%h, required 0/b2", parity_err_m, pout_m);
        end
        pout_ready = 1'b1;
        step();
        pout_ready = 1'b0;
        for (int i = 0; i < FRAME; i++) send_bit(frame_bit(8'hB2, 1'b1, i));
        vectors++;
        if (parity_err_m !== 1'b1 || pout_m !== 8'hB2 || pout_valid_m !== 1'b1) begin
            miscompares++;
            $display("FAIL parity_bad: perr=%b pout=%h valid=%b, required 1/b2/1",
                     parity_err_m, pout_m, pout_valid_m);
        end
        pout_ready = 1'b1;
        step();
        pout_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_stall();
        test_async_reset();
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
